// File: rtl/ibex_cheri_ccall_seq_pkg.sv
// Shared types and constants for the CHERI CCall sequencer and its priority checker.
package ibex_cheri_ccall_seq_pkg;

   localparam int OTYPE_W              = 18;
   localparam int PERM_W               = 12;
   localparam int CHERI_PERM_EXE_BIT   = 1;
   localparam int CHERI_PERM_CCALL_BIT = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      C1    = 3'd2,
      C2    = 3'd3,
      EXC   = 3'd4
   } ccall_seq_state_e;

   typedef enum logic [1:0] {
      CCALL_CCALL      = 2'd0,
      CCALL_CRETURN    = 2'd1,
      CCALLFAST_CYCLE1 = 2'd2,
      CCALLFAST_CYCLE2 = 2'd3
   } cheri_ccall_e;

   typedef enum logic [4:0] {
      CAUSE_NONE           = 5'h00,
      CAUSE_LENGTH         = 5'h01,
      CAUSE_TAG            = 5'h02,
      CAUSE_SEAL           = 5'h03,
      CAUSE_TYPE           = 5'h04,
      CAUSE_CALL_TRAP      = 5'h05,
      CAUSE_RETURN_TRAP    = 5'h06,
      CAUSE_PERMIT_EXECUTE = 5'h11,
      CAUSE_PERMIT_CCALL   = 5'h19
   } c_exc_cause_e;

endpackage

// File: rtl/ibex_cheri_ccall_check.sv
// Combinational CCall check: first failing rule in priority order gives cause and register.
module ibex_cheri_ccall_check
   import ibex_cheri_ccall_seq_pkg::*;
#(
   parameter int OTYPE_W        = 18,
   parameter int PERM_W         = 12,
   parameter int PERM_EXE_BIT   = 1,
   parameter int PERM_CCALL_BIT = 8
) (
   input  logic [1:0]         op_i,
   input  logic [4:0]         cs1_idx_i,
   input  logic [4:0]         cs2_idx_i,
   input  logic               cs1_tag_i,
   input  logic               cs2_tag_i,
   input  logic               cs1_sealed_i,
   input  logic               cs2_sealed_i,
   input  logic [OTYPE_W-1:0] cs1_otype_i,
   input  logic [OTYPE_W-1:0] cs2_otype_i,
   input  logic [PERM_W-1:0]  cs1_perm_i,
   input  logic [PERM_W-1:0]  cs2_perm_i,
   input  logic               cs1_inbounds_i,
   output logic               fail_o,
   output logic [4:0]         cause_o,
   output logic [4:0]         reg_o
);

   always_comb begin
      fail_o  = 1'b1;
      cause_o = CAUSE_NONE;
      reg_o   = cs1_idx_i;
      if (op_i == CCALL_CCALL) begin
         cause_o = CAUSE_CALL_TRAP;
      end else if (op_i == CCALL_CRETURN) begin
         cause_o = CAUSE_RETURN_TRAP;
      end else if (!cs1_tag_i) begin
         cause_o = CAUSE_TAG;
      end else if (!cs2_tag_i) begin
         cause_o = CAUSE_TAG;
         reg_o   = cs2_idx_i;
      end else if (!cs1_sealed_i) begin
         cause_o = CAUSE_SEAL;
      end else if (!cs2_sealed_i) begin
         cause_o = CAUSE_SEAL;
         reg_o   = cs2_idx_i;
      end else if (cs1_otype_i != cs2_otype_i) begin
         cause_o = CAUSE_TYPE;
      end else if (!cs1_perm_i[PERM_CCALL_BIT]) begin
         cause_o = CAUSE_PERMIT_CCALL;
      end else if (!cs2_perm_i[PERM_CCALL_BIT]) begin
         cause_o = CAUSE_PERMIT_CCALL;
         reg_o   = cs2_idx_i;
      end else if (!cs1_perm_i[PERM_EXE_BIT]) begin
         cause_o = CAUSE_PERMIT_EXECUTE;
      end else if (cs2_perm_i[PERM_EXE_BIT]) begin
         // The data capability must not be executable.
         cause_o = CAUSE_PERMIT_EXECUTE;
         reg_o   = cs2_idx_i;
      end else if (!cs1_inbounds_i) begin
         cause_o = CAUSE_LENGTH;
      end else begin
         fail_o  = 1'b0;
      end
   end

endmodule

// File: rtl/ibex_cheri_ccall_seq.sv
// CCall sequencer: latch operands, check, then raise an exception or issue the two CCALLFAST writes.
module ibex_cheri_ccall_seq
   import ibex_cheri_ccall_seq_pkg::*;
#(
   parameter int OTYPE_W        = 18,
   parameter int PERM_W         = 12,
   parameter int PERM_EXE_BIT   = 1,
   parameter int PERM_CCALL_BIT = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic [1:0]         ccall_op_i,
   input  logic               flush_i,
   input  logic [4:0]         cs1_idx_i,
   input  logic [4:0]         cs2_idx_i,
   input  logic               cs1_tag_i,
   input  logic               cs2_tag_i,
   input  logic               cs1_sealed_i,
   input  logic               cs2_sealed_i,
   input  logic [OTYPE_W-1:0] cs1_otype_i,
   input  logic [OTYPE_W-1:0] cs2_otype_i,
   input  logic [PERM_W-1:0]  cs1_perm_i,
   input  logic [PERM_W-1:0]  cs2_perm_i,
   input  logic               cs1_inbounds_i,
   output logic               busy_o,
   output logic [1:0]         cycle_o,
   output logic               pcc_we_o,
   output logic               jump_o,
   output logic               idc_we_o,
   output logic               done_o,
   output logic               exc_o,
   output logic [4:0]         exc_cause_o,
   output logic [4:0]         exc_reg_o
);

   ccall_seq_state_e   state_q, state_d;
   logic [1:0]         op_q;
   logic [4:0]         cs1_idx_q, cs2_idx_q;
   logic               cs1_tag_q, cs2_tag_q, cs1_sealed_q, cs2_sealed_q, cs1_inb_q;
   logic [OTYPE_W-1:0] cs1_otype_q, cs2_otype_q;
   logic [PERM_W-1:0]  cs1_perm_q, cs2_perm_q;
   logic [4:0]         cause_q, ereg_q;

   logic               chk_fail;
   logic [4:0]         chk_cause, chk_reg;
   logic               accept;

   assign accept = (state_q == IDLE) && start_i && !flush_i;

   ibex_cheri_ccall_check #(
      .OTYPE_W       (OTYPE_W),
      .PERM_W        (PERM_W),
      .PERM_EXE_BIT  (PERM_EXE_BIT),
      .PERM_CCALL_BIT(PERM_CCALL_BIT)
   ) u_check (
      .op_i          (op_q),
      .cs1_idx_i     (cs1_idx_q),
      .cs2_idx_i     (cs2_idx_q),
      .cs1_tag_i     (cs1_tag_q),
      .cs2_tag_i     (cs2_tag_q),
      .cs1_sealed_i  (cs1_sealed_q),
      .cs2_sealed_i  (cs2_sealed_q),
      .cs1_otype_i   (cs1_otype_q),
      .cs2_otype_i   (cs2_otype_q),
      .cs1_perm_i    (cs1_perm_q),
      .cs2_perm_i    (cs2_perm_q),
      .cs1_inbounds_i(cs1_inb_q),
      .fail_o        (chk_fail),
      .cause_o       (chk_cause),
      .reg_o         (chk_reg)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         op_q         <= '0;
         cs1_idx_q    <= '0;
         cs2_idx_q    <= '0;
         cs1_tag_q    <= 1'b0;
         cs2_tag_q    <= 1'b0;
         cs1_sealed_q <= 1'b0;
         cs2_sealed_q <= 1'b0;
         cs1_inb_q    <= 1'b0;
         cs1_otype_q  <= '0;
         cs2_otype_q  <= '0;
         cs1_perm_q   <= '0;
         cs2_perm_q   <= '0;
         cause_q      <= CAUSE_NONE;
         ereg_q       <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q         <= ccall_op_i;
            cs1_idx_q    <= cs1_idx_i;
            cs2_idx_q    <= cs2_idx_i;
            cs1_tag_q    <= cs1_tag_i;
            cs2_tag_q    <= cs2_tag_i;
            cs1_sealed_q <= cs1_sealed_i;
            cs2_sealed_q <= cs2_sealed_i;
            cs1_inb_q    <= cs1_inbounds_i;
            cs1_otype_q  <= cs1_otype_i;
            cs2_otype_q  <= cs2_otype_i;
            cs1_perm_q   <= cs1_perm_i;
            cs2_perm_q   <= cs2_perm_i;
         end
         if (state_q == CHECK) begin
            cause_q <= chk_cause;
            ereg_q  <= chk_reg;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_i) state_d = CHECK;
         CHECK:   state_d = chk_fail ? EXC : C1;
         C1:      state_d = C2;
         C2:      state_d = IDLE;
         EXC:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   // Strobes are state-decoded, with flush as the only qualifier so a killed cycle never commits.
   always_comb begin
      busy_o      = (state_q != IDLE);
      cycle_o     = CCALL_CCALL;
      pcc_we_o    = 1'b0;
      jump_o      = 1'b0;
      idc_we_o    = 1'b0;
      done_o      = 1'b0;
      exc_o       = 1'b0;
      exc_cause_o = CAUSE_NONE;
      exc_reg_o   = '0;
      unique case (state_q)
         C1: begin
            cycle_o  = CCALLFAST_CYCLE1;
            pcc_we_o = !flush_i;
            jump_o   = !flush_i;
         end
         C2: begin
            cycle_o  = CCALLFAST_CYCLE2;
            idc_we_o = !flush_i;
            done_o   = !flush_i;
         end
         EXC: begin
            exc_o       = !flush_i;
            exc_cause_o = cause_q;
            exc_reg_o   = ereg_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ibex_cheri_ccall_seq.sv
// Bench for the CCall sequencer: directed vector table, multi-cycle corner cases, random run vs model.
module tb_ibex_cheri_ccall_seq;
   import ibex_cheri_ccall_seq_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i, flush_i;
   logic [1:0]  ccall_op_i;
   logic [4:0]  cs1_idx_i, cs2_idx_i;
   logic        cs1_tag_i, cs2_tag_i, cs1_sealed_i, cs2_sealed_i, cs1_inbounds_i;
   logic [17:0] cs1_otype_i, cs2_otype_i;
   logic [11:0] cs1_perm_i, cs2_perm_i;
   logic        busy_o, pcc_we_o, jump_o, idc_we_o, done_o, exc_o;
   logic [1:0]  cycle_o;
   logic [4:0]  exc_cause_o, exc_reg_o;

   always #5 clk_i = ~clk_i;

   ibex_cheri_ccall_seq dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .ccall_op_i(ccall_op_i),
      .flush_i(flush_i), .cs1_idx_i(cs1_idx_i), .cs2_idx_i(cs2_idx_i),
      .cs1_tag_i(cs1_tag_i), .cs2_tag_i(cs2_tag_i), .cs1_sealed_i(cs1_sealed_i),
      .cs2_sealed_i(cs2_sealed_i), .cs1_otype_i(cs1_otype_i), .cs2_otype_i(cs2_otype_i),
      .cs1_perm_i(cs1_perm_i), .cs2_perm_i(cs2_perm_i), .cs1_inbounds_i(cs1_inbounds_i),
      .busy_o(busy_o), .cycle_o(cycle_o), .pcc_we_o(pcc_we_o), .jump_o(jump_o),
      .idc_we_o(idc_we_o), .done_o(done_o), .exc_o(exc_o), .exc_cause_o(exc_cause_o),
      .exc_reg_o(exc_reg_o)
   );

   typedef struct {
      logic [1:0]  op;
      logic [4:0]  i1, i2;
      logic        t1, t2, s1, s2, inb;
      logic [17:0] o1, o2;
      logic [11:0] p1, p2;
   } ops_t;

   typedef struct {
      ops_t       ops;
      logic       fast;
      logic [4:0] cause;
      logic [4:0] ereg;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: cycles elapsed since an accepted start (0 = idle) plus the predicted outcome.
   int         ph = 0;
   logic       m_fast = 1'b0;
   logic [4:0] m_cause = 5'd0, m_reg = 5'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic ops_t good();
      ops_t o;
      o.op = CCALLFAST_CYCLE1; o.i1 = 5'd3; o.i2 = 5'd7;
      o.t1 = 1'b1; o.t2 = 1'b1; o.s1 = 1'b1; o.s2 = 1'b1; o.inb = 1'b1;
      o.o1 = 18'd5; o.o2 = 18'd5;
      o.p1 = 12'h102; o.p2 = 12'h100;
      return o;
   endfunction

   function automatic vec_t mkv(input ops_t o, input logic f, input logic [4:0] c, input logic [4:0] r);
      vec_t v;
      v.ops = o; v.fast = f; v.cause = c; v.ereg = r;
      return v;
   endfunction

   // Reference: ordered list of (failing?, cause, register); the first failing entry wins.
   function automatic void ref_eval(input ops_t o, output logic fast, output logic [4:0] cause,
                                    output logic [4:0] r);
      logic       bad [12];
      logic [4:0] cs  [12];
      logic [4:0] rg  [12];
      bad[0]  = (o.op == 2'd0);   cs[0]  = 5'h05; rg[0]  = o.i1;
      bad[1]  = (o.op == 2'd1);   cs[1]  = 5'h06; rg[1]  = o.i1;
      bad[2]  = !o.t1;            cs[2]  = 5'h02; rg[2]  = o.i1;
      bad[3]  = !o.t2;            cs[3]  = 5'h02; rg[3]  = o.i2;
      bad[4]  = !o.s1;            cs[4]  = 5'h03; rg[4]  = o.i1;
      bad[5]  = !o.s2;            cs[5]  = 5'h03; rg[5]  = o.i2;
      bad[6]  = (o.o1 != o.o2);   cs[6]  = 5'h04; rg[6]  = o.i1;
      bad[7]  = !o.p1[8];         cs[7]  = 5'h19; rg[7]  = o.i1;
      bad[8]  = !o.p2[8];         cs[8]  = 5'h19; rg[8]  = o.i2;
      bad[9]  = !o.p1[1];         cs[9]  = 5'h11; rg[9]  = o.i1;
      bad[10] = o.p2[1];          cs[10] = 5'h11; rg[10] = o.i2;
      bad[11] = !o.inb;           cs[11] = 5'h01; rg[11] = o.i1;
      fast = 1'b1; cause = 5'h00; r = 5'd0;
      for (int k = 11; k >= 0; k--)
         if (bad[k]) begin fast = 1'b0; cause = cs[k]; r = rg[k]; end
   endfunction

   task automatic drive(input ops_t o);
      ccall_op_i = o.op; cs1_idx_i = o.i1; cs2_idx_i = o.i2;
      cs1_tag_i = o.t1; cs2_tag_i = o.t2; cs1_sealed_i = o.s1; cs2_sealed_i = o.s2;
      cs1_otype_i = o.o1; cs2_otype_i = o.o2; cs1_perm_i = o.p1; cs2_perm_i = o.p2;
      cs1_inbounds_i = o.inb;
   endtask

   function automatic ops_t cur();
      ops_t o;
      o.op = ccall_op_i; o.i1 = cs1_idx_i; o.i2 = cs2_idx_i;
      o.t1 = cs1_tag_i; o.t2 = cs2_tag_i; o.s1 = cs1_sealed_i; o.s2 = cs2_sealed_i;
      o.o1 = cs1_otype_i; o.o2 = cs2_otype_i; o.p1 = cs1_perm_i; o.p2 = cs2_perm_i;
      o.inb = cs1_inbounds_i;
      return o;
   endfunction

   task automatic cmp_all();
      logic e_pcc, e_idc, e_exc;
      e_pcc = (ph == 2) && m_fast && !flush_i;
      e_exc = (ph == 2) && !m_fast && !flush_i;
      e_idc = (ph == 3) && !flush_i;
      chk("busy", busy_o, ph != 0);
      chk("pcc_we", pcc_we_o, e_pcc);
      chk("jump", jump_o, e_pcc);
      chk("idc_we", idc_we_o, e_idc);
      chk("done", done_o, e_idc);
      chk("exc", exc_o, e_exc);
      if (e_exc) begin
         chk("exc_cause", exc_cause_o, m_cause);
         chk("exc_reg", exc_reg_o, m_reg);
      end
      if (e_pcc) chk("cycle_c1", cycle_o, 2'd2);
      if (e_idc) chk("cycle_c2", cycle_o, 2'd3);
   endtask

   task automatic model_upd();
      if (flush_i) ph = 0;
      else if (ph == 0) begin
         if (start_i) begin
            ref_eval(cur(), m_fast, m_cause, m_reg);
            ph = 1;
         end
      end
      else if (ph == 1) ph = 2;
      else if (ph == 2) ph = m_fast ? 3 : 0;
      else ph = 0;
   endtask

   // Called just after a negedge with inputs already set for the coming posedge.
   task automatic cyc();
      #1 cmp_all();
      @(posedge clk_i);
      model_upd();
      @(negedge clk_i);
   endtask

   vec_t tbl [14];
   ops_t o;
   int   dn;

   initial begin
      o = good();
      tbl[0] = mkv(o, 1'b1, 5'h00, 5'd0);
      o = good(); o.t2 = 1'b0;                tbl[1]  = mkv(o, 1'b0, 5'h02, 5'd7);
      o = good(); o.o2 = 18'd6;               tbl[2]  = mkv(o, 1'b0, 5'h04, 5'd3);
      o = good(); o.s1 = 1'b0; o.s2 = 1'b0;   tbl[3]  = mkv(o, 1'b0, 5'h03, 5'd3);
      o = good(); o.op = CCALL_CCALL;         tbl[4]  = mkv(o, 1'b0, 5'h05, 5'd3);
      o = good(); o.op = CCALL_CRETURN;       tbl[5]  = mkv(o, 1'b0, 5'h06, 5'd3);
      o = good(); o.t1 = 1'b0; o.t2 = 1'b0;   tbl[6]  = mkv(o, 1'b0, 5'h02, 5'd3);
      o = good(); o.s2 = 1'b0;                tbl[7]  = mkv(o, 1'b0, 5'h03, 5'd7);
      o = good(); o.p1 = 12'h002;             tbl[8]  = mkv(o, 1'b0, 5'h19, 5'd3);
      o = good(); o.p2 = 12'h000;             tbl[9]  = mkv(o, 1'b0, 5'h19, 5'd7);
      o = good(); o.p1 = 12'h100;             tbl[10] = mkv(o, 1'b0, 5'h11, 5'd3);
      o = good(); o.p2 = 12'h102;             tbl[11] = mkv(o, 1'b0, 5'h11, 5'd7);
      o = good(); o.inb = 1'b0; o.i1 = 5'd31; tbl[12] = mkv(o, 1'b0, 5'h01, 5'd31);
      o = good(); o.op = CCALLFAST_CYCLE2;    tbl[13] = mkv(o, 1'b1, 5'h00, 5'd0);

      rst_ni = 1'b0; start_i = 1'b0; flush_i = 1'b0;
      drive(good());
      #2;
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_pcc", pcc_we_o, 1'b0);
      chk("rst_exc", exc_o, 1'b0);
      chk("rst_cause", exc_cause_o, 5'h00);
      chk("rst_cycle", cycle_o, 2'd0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].ops);
         start_i = 1'b1; cyc();
         start_i = 1'b0; cyc();
         #1;
         chk("tbl_exc", exc_o, !tbl[i].fast);
         chk("tbl_pcc", pcc_we_o, tbl[i].fast);
         if (!tbl[i].fast) begin
            chk("tbl_cause", exc_cause_o, tbl[i].cause);
            chk("tbl_reg", exc_reg_o, tbl[i].ereg);
         end
         cyc(); cyc();
      end

      // Flush in C1, then in C2.
      drive(good());
      start_i = 1'b1; cyc(); start_i = 1'b0; cyc();
      flush_i = 1'b1; #1 chk("flush_c1_pcc", pcc_we_o, 1'b0);
      cyc(); flush_i = 1'b0;
      #1 chk("flush_c1_idle", busy_o, 1'b0);
      cyc(); cyc();
      start_i = 1'b1; cyc(); start_i = 1'b0; cyc(); cyc();
      flush_i = 1'b1; #1;
      chk("flush_c2_idc", idc_we_o, 1'b0);
      chk("flush_c2_done", done_o, 1'b0);
      cyc(); flush_i = 1'b0;
      #1 chk("flush_c2_idle", busy_o, 1'b0);
      cyc();

      // Start together with flush in IDLE is dropped.
      start_i = 1'b1; flush_i = 1'b1; cyc();
      start_i = 1'b0; flush_i = 1'b0;
      #1 chk("start_flush_drop", busy_o, 1'b0);
      cyc();

      // Asynchronous reset while in CHECK.
      start_i = 1'b1; cyc(); start_i = 1'b0;
      #1 chk("check_busy", busy_o, 1'b1);
      rst_ni = 1'b0; #1;
      chk("arst_busy", busy_o, 1'b0);
      chk("arst_pcc", pcc_we_o, 1'b0);
      chk("arst_idc", idc_we_o, 1'b0);
      chk("arst_exc", exc_o, 1'b0);
      ph = 0;
      @(negedge clk_i); rst_ni = 1'b1;
      cyc();

      // start_i held while busy: exactly one sequence retires.
      dn = 0;
      start_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k == 3) start_i = 1'b0;
         #1 if (done_o) dn++;
         cyc();
      end
      chk("one_done", dn, 1);

      // Randomized run against the model.
      for (int k = 0; k < 1500; k++) begin
         o = good();
         if ($urandom_range(3) == 0) o.op = 2'($urandom_range(3));
         if ($urandom_range(9) == 0) o.t1 = 1'b0;
         if ($urandom_range(9) == 0) o.t2 = 1'b0;
         if ($urandom_range(9) == 0) o.s1 = 1'b0;
         if ($urandom_range(9) == 0) o.s2 = 1'b0;
         if ($urandom_range(9) == 0) o.o2 = 18'($urandom);
         if ($urandom_range(7) == 0) o.p1 = 12'($urandom);
         if ($urandom_range(7) == 0) o.p2 = 12'($urandom);
         if ($urandom_range(9) == 0) o.inb = 1'b0;
         o.i1 = 5'($urandom); o.i2 = 5'($urandom);
         drive(o);
         start_i = ($urandom_range(2) == 0);
         flush_i = ($urandom_range(11) == 0);
         cyc();
      end
      start_i = 1'b0; flush_i = 1'b0;
      cyc(); cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
